// File: rtl/approx_mult_rr_scheduler.sv
// approx_mult_rr_scheduler
//   One leading-one-truncating approximate multiplier shared by N_REQ requesters.
//   A round-robin arbiter grants one operand pair at a time. A four-state FSM runs
//   IDLE -> LOD -> MUL -> OUT, and the tagged result leaves on a valid/ready port.
// Ports
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_ready  : one-hot grant, combinational, only in IDLE
//   req_a/b    : packed operands, requester i at [i*WIDTH +: WIDTH]
//   res_valid  : result valid (registered)
//   res_ready  : consumer accepts result
//   res_data   : approximate product, 2*WIDTH bits
//   res_id     : requester index owning res_data
//   busy       : high whenever the FSM is not in IDLE
module approx_mult_rr_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NUM   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [2*WIDTH-1:0]         res_data,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic                       busy
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned KW  = $clog2(WIDTH);
  localparam int unsigned SSW = $clog2(WIDTH - NUM + 1);
  localparam int unsigned SHW = $clog2(2 * (WIDTH - NUM) + 1);
  localparam int unsigned PW  = 2 * NUM;
  localparam int unsigned RW  = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOD  = 2'd1,
    S_MUL  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Kept mantissa and its right-shift for one operand
  typedef struct packed {
    logic [NUM-1:0] m;
    logic [SSW-1:0] s;
  } lod_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_rr_ptr;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [IDW-1:0]     r_id;
  logic [NUM-1:0]     r_m_a;
  logic [NUM-1:0]     r_m_b;
  logic [SHW-1:0]     r_sh;
  logic               r_res_valid;
  logic [RW-1:0]      r_res_data;
  logic [IDW-1:0]     r_res_id;

  logic               w_gnt_hit;
  logic [IDW-1:0]     w_gnt_id;
  logic [IDW-1:0]     w_rr_nxt;
  logic [N_REQ-1:0]   w_req_ready;
  logic               w_xfer;
  lod_t               w_lod_a;
  lod_t               w_lod_b;
  logic [PW-1:0]      w_prod;
  logic [RW-1:0]      w_shifted;

  // Index of the highest set bit; zero for a zero operand
  function automatic logic [KW-1:0] f_msb(input logic [WIDTH-1:0] x);
    logic [KW-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (x[i]) k = KW'(i);
    end
    return k;
  endfunction

  // Keep NUM bits starting at the leading one; small operands pass exactly
  function automatic lod_t f_lod(input logic [WIDTH-1:0] x);
    lod_t          r;
    logic [KW-1:0] k;
    logic [KW-1:0] sft;
    k   = f_msb(x);
    sft = k - KW'(NUM - 1);
    r.m = x[NUM-1:0];
    r.s = '0;
    if (k >= KW'(NUM)) begin
      r.m = NUM'(x >> sft);
      r.s = SSW'(sft);
    end
    return r;
  endfunction

  // Round-robin search starting at r_rr_ptr
  always_comb begin
    int unsigned idx;
    w_gnt_hit = 1'b0;
    w_gnt_id  = '0;
    idx       = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = 32'(r_rr_ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_gnt_hit && req_valid[IDW'(idx)]) begin
        w_gnt_hit = 1'b1;
        w_gnt_id  = IDW'(idx);
      end
    end
  end

  assign w_rr_nxt = (w_gnt_id == IDW'(N_REQ - 1)) ? '0 : w_gnt_id + IDW'(1);

  // Next-state and grant decode
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_hit) begin
          w_req_ready = N_REQ'(1) << w_gnt_id;
          w_state_nxt = S_LOD;
        end
      end
      S_LOD:   w_state_nxt = S_MUL;
      S_MUL:   w_state_nxt = S_OUT;
      S_OUT: begin
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) w_req_ready = '0;
  end

  assign w_xfer    = (r_state == S_IDLE) && w_gnt_hit && !rst;
  assign w_lod_a   = f_lod(r_a);
  assign w_lod_b   = f_lod(r_b);
  assign w_prod    = PW'(r_m_a) * PW'(r_m_b);
  assign w_shifted = RW'(w_prod) << r_sh;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, leading-one stage, product stage and result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_m_a       <= '0;
      r_m_b       <= '0;
      r_sh        <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      if (w_xfer) begin
        r_a      <= req_a[w_gnt_id*WIDTH +: WIDTH];
        r_b      <= req_b[w_gnt_id*WIDTH +: WIDTH];
        r_id     <= w_gnt_id;
        r_rr_ptr <= w_rr_nxt;
      end
      if (r_state == S_LOD) begin
        r_m_a <= w_lod_a.m;
        r_m_b <= w_lod_b.m;
        r_sh  <= SHW'(w_lod_a.s) + SHW'(w_lod_b.s);
      end
      if (r_state == S_MUL) begin
        r_res_data  <= w_shifted;
        r_res_id    <= r_id;
        r_res_valid <= 1'b1;
      end
      if ((r_state == S_OUT) && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_approx_mult_rr_scheduler.sv
// Bench for approx_mult_rr_scheduler: transaction-level model plus directed and
// randomized stimulus; every cycle's outputs are compared at the falling edge.
module tb_approx_mult_rr_scheduler;
  localparam int N   = 4;
  localparam int W   = 64;
  localparam int NUM = 7;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             res_valid;
  logic             res_ready;
  logic [2*W-1:0]   res_data;
  logic [IDW-1:0]   res_id;
  logic             busy;

  always #5 clk = ~clk;

  approx_mult_rr_scheduler #(.N_REQ(N), .WIDTH(W), .NUM(NUM)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: job in flight, cycles since grant, round-robin pointer, result regs
  bit           m_known  = 1'b0;
  bit           m_active = 1'b0;
  int           m_age    = 0;
  int           m_rr     = 0;
  logic [W-1:0] m_a, m_b;
  int           m_id     = 0;
  bit           m_rv     = 1'b0;
  logic [127:0] m_rd     = '0;
  int           m_rid    = 0;

  // Inputs sampled at the falling edge, consumed at the next rising edge
  bit           s_rst = 1'b0;
  logic [N*W-1:0] s_a, s_b;
  bit           s_rr  = 1'b0;
  int           s_g   = -1;

  int           g_id[$];
  int           g_cyc[$];
  int           r_id[$];
  int           r_cyc[$];
  logic [127:0] r_data[$];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  function automatic void trunc(input logic [W-1:0] x, output logic [W-1:0] m, output int s);
    int k;
    k = 0;
    for (int i = 0; i < W; i++) if (x[i]) k = i;
    if (k < NUM) begin
      m = x & ((64'(1) << NUM) - 64'(1));
      s = 0;
    end else begin
      s = k - NUM + 1;
      m = x >> s;
    end
  endfunction

  function automatic logic [127:0] approx(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma, mb;
    int sa, sb;
    trunc(a, ma, sa);
    trunc(b, mb, sb);
    return 128'(ma * mb) << (sa + sb);
  endfunction

  function automatic int model_grant(input logic [N-1:0] v, input int rr);
    for (int off = 0; off < N; off++) begin
      if (v[(rr + off) % N]) return (rr + off) % N;
    end
    return -1;
  endfunction

  // Compare process: expected outputs from model state and current inputs
  always @(negedge clk) begin
    int g;
    logic [N-1:0] e_rdy;
    g = model_grant(req_valid, m_rr);
    e_rdy = '0;
    if (!rst && !m_active && g >= 0) e_rdy = 4'(1) << g;
    if (m_known) begin
      chk("req_ready", 128'(req_ready), 128'(e_rdy));
      chk("busy",      128'(busy),      128'(m_active));
      chk("res_valid", 128'(res_valid), 128'(m_rv));
      chk("res_id",    128'(res_id),    128'(m_rid));
      chk("res_data",  res_data,        m_rd);
    end
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          g_id.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
      if (res_valid && res_ready) begin
        r_id.push_back(int'(res_id));
        r_cyc.push_back(cyc);
        r_data.push_back(res_data);
      end
    end
    s_rst = rst;
    s_a   = req_a;
    s_b   = req_b;
    s_rr  = res_ready;
    s_g   = (rst || m_active) ? -1 : g;
  end

  // Model advance at each rising edge
  always @(posedge clk) begin
    cyc++;
    if (s_rst) begin
      m_known  = 1'b1;
      m_active = 1'b0;
      m_rr     = 0;
      m_rv     = 1'b0;
      m_rd     = '0;
      m_rid    = 0;
    end else if (m_known) begin
      if (!m_active) begin
        if (s_g >= 0) begin
          m_active = 1'b1;
          m_age    = 1;
          m_a      = s_a[s_g*W +: W];
          m_b      = s_b[s_g*W +: W];
          m_id     = s_g;
          m_rr     = (s_g + 1) % N;
        end
      end else if (m_age < 3) begin
        m_age++;
        if (m_age == 3) begin
          m_rv  = 1'b1;
          m_rd  = approx(m_a, m_b);
          m_rid = m_id;
        end
      end else if (s_rr) begin
        m_rv     = 1'b0;
        m_active = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] x;
    x = {$urandom, $urandom};
    if ($urandom_range(0, 15) == 0) return '0;
    return x >> $urandom_range(0, 63);
  endfunction

  // Single job from requester i; checks data, id and grant-to-result latency
  task automatic do_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [127:0] exp_d);
    int n0, g0;
    bit seen;
    n0 = r_id.size();
    g0 = g_id.size();
    set_op(i, a, b);
    req_valid = 4'(1) << i;
    res_ready = 1'b1;
    step();
    req_valid = '0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (r_id.size() > n0) seen = 1'b1;
      else step();
    end
    if (!seen || g_id.size() <= g0) begin
      n_cmp++;
      n_err++;
      $display("FAIL do_one_timeout req=%0d got=no_result exp=result", i);
    end else begin
      chk("one_data", r_data[n0], exp_d);
      chk("one_id", 128'(r_id[n0]), 128'(i));
      chk("one_gnt_id", 128'(g_id[g0]), 128'(i));
      chk("one_latency", 128'(r_cyc[n0] - g_cyc[g0]), 128'(3));
    end
  endtask

  initial begin
    int n0, g0;
    bit seen;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;

    // Pin the reference arithmetic with hand-computed values
    chk("pin_5x6",     approx(64'd5, 64'd6), 128'd30);
    chk("pin_ff00x3",  approx(64'hFF00, 64'd3), 128'h2FA00);
    chk("pin_zero",    approx(64'd0, 64'hFFFF_FFFF_FFFF_FFFF), 128'd0);
    chk("pin_2p63",    approx(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000), 128'(1) << 126);

    step(); step();
    // Reset state
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_res_data", res_data, 128'(0));
    rst = 1'b0;

    do_one(2, 64'd5, 64'd6, 128'd30);
    do_one(1, 64'hFF00, 64'd3, 128'h2FA00);
    do_one(0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0);
    do_one(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 128'(1) << 126);

    // All requesters busy: grants 0,1,2,3,0 four cycles apart
    rst = 1'b1;
    step();
    rst = 1'b0;
    g_id.delete();
    g_cyc.delete();
    for (int i = 0; i < N; i++) set_op(i, rnd_op(), rnd_op());
    req_valid = 4'hF;
    res_ready = 1'b1;
    repeat (20) step();
    req_valid = '0;
    repeat (5) step();
    if (g_id.size() < 5) begin
      n_cmp++;
      n_err++;
      $display("FAIL rr_count got=%0d exp>=5", g_id.size());
    end else begin
      for (int k = 0; k < 5; k++) chk("rr_order", 128'(g_id[k]), 128'(k % N));
      for (int k = 0; k < 4; k++) chk("rr_gap", 128'(g_cyc[k+1] - g_cyc[k]), 128'(4));
    end

    // Back-pressure in OUT: everything held for five cycles
    set_op(1, 64'd100, 64'd7);
    req_valid = 4'b0010;
    res_ready = 1'b0;
    step();
    req_valid = 4'hF;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      if (res_valid) seen = 1'b1;
      else step();
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL hold_timeout got=no_valid exp=valid");
    end
    for (int t = 0; t < 5; t++) begin
      chk("hold_valid", 128'(res_valid), 128'(1));
      chk("hold_data", res_data, 128'd700);
      chk("hold_id", 128'(res_id), 128'(1));
      chk("hold_ready", 128'(req_ready), 128'(0));
      chk("hold_busy", 128'(busy), 128'(1));
      step();
    end
    res_ready = 1'b1;
    step();
    req_valid = '0;
    repeat (6) step();

    // Reset during MUL abandons the job and returns the pointer to 0
    set_op(2, 64'd9, 64'd9);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    n0 = r_id.size();
    step();
    rst = 1'b0;
    chk("mulrst_busy", 128'(busy), 128'(0));
    chk("mulrst_valid", 128'(res_valid), 128'(0));
    g0 = g_id.size();
    set_op(0, 64'd3, 64'd4);
    set_op(3, 64'd5, 64'd5);
    req_valid = 4'b1001;
    step();
    req_valid = '0;
    repeat (5) step();
    chk("mulrst_results", 128'(r_id.size()), 128'(n0 + 1));
    if (g_id.size() <= g0) begin
      n_cmp++;
      n_err++;
      $display("FAIL mulrst_grant got=none exp=0");
    end else begin
      chk("mulrst_grant", 128'(g_id[g0]), 128'(0));
    end

    // Randomized traffic with occasional resets
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) set_op(i, rnd_op(), rnd_op());
      req_valid = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
